// File: rtl/shift_sub_div.sv
// shift_sub_div: sequential restoring divider, one quotient bit per clock.
// Uses the same start/done handshake as the shift-add multiplier next to it.
// Optional feature macro: SHIFT_SUB_DIV_SIGNED_EN (two's complement operands,
// truncating division). When it is undefined, all operands are unsigned.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; operands are captured on start
// CALC  | one shift-subtract step per cycle, WIDTH cycles in total
// DONE  | one-cycle done pulse; quotient/remainder are already valid

module shift_sub_div #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
    logic             accept;
    logic             div_zero;
    logic [WIDTH-1:0] acc_dvd, acc_dvs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             take;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic [WIDTH-1:0] res_q, res_r;

    assign accept   = (state == IDLE) && start;
    assign div_zero = (divisor == '0);

    // The shifted partial remainder can reach 2*divisor-1, so it needs WIDTH+1
    // bits; after a successful subtract (or a restore) it fits in WIDTH again.
    assign rem_sh  = {rem_r, quo_r[WIDTH-1]};
    assign take    = (rem_sh >= {1'b0, dvs_r});
    assign trial   = rem_sh - {1'b0, dvs_r};
    assign rem_nxt = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nxt = {quo_r[WIDTH-2:0], take};

`ifdef SHIFT_SUB_DIV_SIGNED_EN
    logic neg_q, neg_r;

    // Core always divides magnitudes; the most-negative value's magnitude is
    // still representable as an unsigned WIDTH-bit number.
    assign acc_dvd = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign acc_dvs = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign res_q   = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    assign res_r   = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;

    // Sign correction flags captured with the operands
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign acc_dvd = dividend;
    assign acc_dvs = divisor;
    assign res_q   = quo_nxt;
    assign res_r   = rem_nxt;
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a zero divisor skips CALC entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = div_zero ? DONE : CALC;
            CALC: if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CALC) || (state == DONE);
    assign done = (state == DONE);

    // Working registers and result registers; results load on DONE entry only
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            rem_r <= '0;
            quo_r <= acc_dvd;
            dvs_r <= acc_dvs;
            if (div_zero) begin
                quotient  <= '1;
                remainder <= dividend;
                dbz       <= 1'b1;
            end
        end else if (state == CALC) begin
            rem_r <= rem_nxt;
            quo_r <= quo_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                quotient  <= res_q;
                remainder <= res_r;
                dbz       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_sub_div.sv
// tb_shift_sub_div: directed checks of the shift_sub_div divider (WIDTH=4).
module tb_shift_sub_div;

    localparam int W = 4;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    int checks = 0;
    int errors = 0;

    shift_sub_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle and count negedges until done (timeout -> -1).
    task automatic issue_and_wait(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                  output int lat);
        @(negedge clk);
        start = 1'b1; dividend = dvd; divisor = dvs;
        @(negedge clk);
        start = 1'b0; dividend = 4'hA; divisor = 4'h0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", dbz); end
        checks++; if (quotient !== 4'h0) begin errors++; $display("FAIL reset_q got %h exp 0", quotient); end
        checks++; if (remainder !== 4'h0) begin errors++; $display("FAIL reset_r got %h exp 0", remainder); end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    // 13/3 cycle by cycle: busy T1..T5, done only at T5, result 4 r1.
    task automatic test_basic_timing();
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0; dividend = 4'h7; divisor = 4'h0;
            checks++;
            if (busy !== (k <= 5)) begin errors++; $display("FAIL basic_busy T%0d got %b exp %b", k, busy, (k <= 5)); end
            checks++;
            if (done !== (k == 5)) begin errors++; $display("FAIL basic_done T%0d got %b exp %b", k, done, (k == 5)); end
            if (k == 4) begin
                checks++;
                if (quotient !== 4'h0) begin errors++; $display("FAIL basic_q_early got %h exp 0", quotient); end
            end
            if (k == 5) begin
                checks++; if (quotient !== 4'd4) begin errors++; $display("FAIL basic_q got %0d exp 4", quotient); end
                checks++; if (remainder !== 4'd1) begin errors++; $display("FAIL basic_r got %0d exp 1", remainder); end
                checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b exp 0", dbz); end
            end
        end
    endtask

    task automatic test_values();
        logic [W-1:0] vd [5] = '{4'd5, 4'd15, 4'd15, 4'd0, 4'd14};
        logic [W-1:0] vs [5] = '{4'd7, 4'd1, 4'd15, 4'd5, 4'd4};
        logic [W-1:0] eq [5] = '{4'd0, 4'd15, 4'd1, 4'd0, 4'd3};
        logic [W-1:0] er [5] = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd2};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue_and_wait(vd[i], vs[i], lat);
            checks++; if (lat !== 5) begin errors++; $display("FAIL val%0d_lat got %0d exp 5", i, lat); end
            checks++; if (quotient !== eq[i]) begin errors++; $display("FAIL val%0d_q got %0d exp %0d", i, quotient, eq[i]); end
            checks++; if (remainder !== er[i]) begin errors++; $display("FAIL val%0d_r got %0d exp %0d", i, remainder, er[i]); end
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        issue_and_wait(4'd9, 4'd0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_lat got %0d exp 1", lat); end
        checks++; if (quotient !== 4'hF) begin errors++; $display("FAIL dbz_q got %h exp f", quotient); end
        checks++; if (remainder !== 4'd9) begin errors++; $display("FAIL dbz_r got %0d exp 9", remainder); end
        checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b exp 1", dbz); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dbz_after got done=%b busy=%b exp 0 0", done, busy); end
        // 8/2: dbz must hold through CALC and clear on DONE
        start = 1'b1; dividend = 4'd8; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        checks++; if (dbz !== 1'b1 || quotient !== 4'hF) begin errors++; $display("FAIL dbz_hold got dbz=%b q=%h exp 1 f", dbz, quotient); end
        lat = 1;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat !== 5) begin errors++; $display("FAIL dbz_next_lat got %0d exp 5", lat); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL dbz_clear got %b exp 0", dbz); end
        checks++; if (quotient !== 4'd4 || remainder !== 4'd0) begin errors++; $display("FAIL dbz_next got %0d r%0d exp 4 r0", quotient, remainder); end
    endtask

    // start during busy is dropped; start at T6 (back in IDLE) is accepted.
    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);   // T1
        start = 1'b0;
        @(negedge clk);   // T2
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        @(negedge clk);   // T3
        start = 1'b0;
        @(negedge clk);   // T4
        @(negedge clk);   // T5
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done got %b exp 1", done); end
        checks++; if (quotient !== 4'd4 || remainder !== 4'd1) begin errors++; $display("FAIL ign_res got %0d r%0d exp 4 r1", quotient, remainder); end
        @(negedge clk);   // T6
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle got busy=%b exp 0", busy); end
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_lat got %0d exp 5", lat); end
        checks++; if (quotient !== 4'd3 || remainder !== 4'd0) begin errors++; $display("FAIL b2b_res got %0d r%0d exp 3 r0", quotient, remainder); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit saw_done;
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);   // T1
        start = 1'b0;
        @(negedge clk);   // T2
        @(negedge clk);   // T3
        n_rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin errors++; $display("FAIL rstmid_ctl got busy=%b done=%b dbz=%b exp 0 0 0", busy, done, dbz); end
        checks++; if (quotient !== 4'd0 || remainder !== 4'd0) begin errors++; $display("FAIL rstmid_res got %0d r%0d exp 0 r0", quotient, remainder); end
        @(negedge clk);
        n_rst = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_nodone got %b exp 0", saw_done); end
        issue_and_wait(4'd12, 4'd5, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL rstmid_lat got %0d exp 5", lat); end
        checks++; if (quotient !== 4'd2 || remainder !== 4'd2) begin errors++; $display("FAIL rstmid_res2 got %0d r%0d exp 2 r2", quotient, remainder); end
    endtask

`ifdef SHIFT_SUB_DIV_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] vd [5] = '{4'h9, 4'h7, 4'h8, 4'hD, 4'h6};
        logic [W-1:0] vs [5] = '{4'h2, 4'hE, 4'hF, 4'h0, 4'h3};
        logic [W-1:0] eq [5] = '{4'hD, 4'hD, 4'h8, 4'hF, 4'h2};
        logic [W-1:0] er [5] = '{4'hF, 4'h1, 4'h0, 4'hD, 4'h0};
        logic         ez [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue_and_wait(vd[i], vs[i], lat);
            checks++; if (lat !== (ez[i] ? 1 : 5)) begin errors++; $display("FAIL sgn%0d_lat got %0d", i, lat); end
            checks++; if (quotient !== eq[i]) begin errors++; $display("FAIL sgn%0d_q got %h exp %h", i, quotient, eq[i]); end
            checks++; if (remainder !== er[i]) begin errors++; $display("FAIL sgn%0d_r got %h exp %h", i, remainder, er[i]); end
            checks++; if (dbz !== ez[i]) begin errors++; $display("FAIL sgn%0d_dbz got %b exp %b", i, dbz, ez[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SHIFT_SUB_DIV_SIGNED_EN
        test_signed();
`else
        test_basic_timing();
        test_values();
        test_div_by_zero();
        test_busy_ignore();
        test_reset_mid();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
